// File: rtl/serial_subtractor16_pkg.sv
// Shared parameters, state encoding and flag helpers for the slice-serial 16-bit subtractor.
package sub_pkg;
    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = $clog2(NSLICE);
    localparam int BASE_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed overflow: operands of differing sign and the result sign departs from the minuend.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction
endpackage

// File: rtl/serial_subtractor16_if.sv
// Start/done request and result bus of the serial subtractor.
interface serial_subtractor16_if;
    import sub_pkg::*;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor16_slice.sv
// Combinational SLICE-bit ripple-borrow subtractor: d = x - y - bi, bo = borrow out.
module sub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             bi,
    output logic [SLICE-1:0] d,
    output logic             bo
);
    logic [SLICE:0] br_s;

    // Ripple the borrow through each bit of the slice.
    always_comb begin
        br_s    = '0;
        d       = '0;
        br_s[0] = bi;
        for (int i = 0; i < SLICE; i++) begin
            d[i]      = x[i] ^ y[i] ^ br_s[i];
            br_s[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br_s[i]);
        end
        bo = br_s[SLICE];
    end
endmodule

// File: rtl/serial_subtractor16.sv
// 16-bit subtractor computing a - b - bin one slice per clock through a single shared slice.
module serial_subtractor16
    import sub_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    serial_subtractor16_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   work_q,   work_d;
    logic [WIDTH-1:0]   diff_q,   diff_d;
    logic               bout_q,   bout_d;
    logic               ovf_q,    ovf_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [BASE_W-1:0]  base_s;
    logic [SLICE-1:0]   x_s;
    logic [SLICE-1:0]   y_s;
    logic [SLICE-1:0]   d_s;
    logic               bo_s;
    logic [WIDTH-1:0]   work_nxt_s;

    assign base_s = BASE_W'(cnt_q) * BASE_W'(SLICE);
    assign x_s    = a_q[base_s +: SLICE];
    assign y_s    = b_q[base_s +: SLICE];

    sub_slice #(.SLICE(SLICE)) u_slice (
        .x  (x_s),
        .y  (y_s),
        .bi (borrow_q),
        .d  (d_s),
        .bo (bo_s)
    );

    // State, operand and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
            work_q   <= {WIDTH{1'b0}};
            diff_q   <= {WIDTH{1'b0}};
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            work_q   <= work_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; results only move on the edge that finishes the last slice.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        borrow_d   = borrow_q;
        work_d     = work_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        work_nxt_s = work_q;
        work_nxt_s[base_s +: SLICE] = d_s;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    cnt_d    = {CNT_W{1'b0}};
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            RUN: begin
                work_d   = work_nxt_s;
                borrow_d = bo_s;
                if (cnt_q == LAST_CNT) begin
                    diff_d  = work_nxt_s;
                    bout_d  = bo_s;
                    ovf_d   = ovf_calc(a_q[WIDTH-1], b_q[WIDTH-1], work_nxt_s[WIDTH-1]);
                    done_d  = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                cnt_d   = {CNT_W{1'b0}};
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor16.sv
// Directed and random scoreboard bench for serial_subtractor16.
module tb_serial_subtractor16;
    logic clk;
    logic reset;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   total_cnt;
    int   pass_cnt;
    int   fail_cnt;

    serial_subtractor16_if bus ();

    serial_subtractor16 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one operation from a falling edge; mode 1 adds ignored start pulses at E2 and in DONE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin, input int mode);
        exp_t        e;
        exp_t        r;
        logic [16:0] full;
        int          n;
        full   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        e.diff = full[15:0];
        e.bout = ({1'b0, a} < ({1'b0, b} + {16'd0, bin}));
        e.ovf  = (a[15] != b[15]) && (e.diff[15] != a[15]);
        sb.push_back(e);

        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.bin   = 1'($urandom);
        n = 0;
        while (!bus.done && n < 10) begin
            check("busy_run", 32'(bus.busy), 32'd1);
            if (mode == 1 && n == 1) begin
                bus.start = 1'b1;
                bus.a     = 16'hFFFF;
            end else if (mode == 1 && n == 2) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd4);
        check("busy_done", 32'(bus.busy), 32'd1);
        r = sb.pop_front();
        check("diff", 32'(bus.diff), 32'(r.diff));
        check("bout", 32'(bus.bout), 32'(r.bout));
        check("ovf", 32'(bus.ovf), 32'(r.ovf));
        if (mode == 1) begin
            bus.start = 1'b1;
            bus.a     = 16'hFFFF;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_end", 32'(bus.busy), 32'd0);
        check("done_single", 32'(bus.done), 32'd0);
        if (mode == 1) begin
            @(negedge clk);
            check("no_accept_busy", 32'(bus.busy), 32'd0);
            check("diff_hold", 32'(bus.diff), 32'(r.diff));
        end
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        bus.bin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);

        reset = 1'b0;
        run_op(16'h1234, 16'h0234, 1'b0, 0);
        check("diff_1000", 32'(bus.diff), 32'h1000);
        run_op(16'h0000, 16'h0001, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 0);
        check("ovf_8000", 32'(bus.ovf), 32'd1);
        run_op(16'h0005, 16'h0005, 1'b1, 0);
        check("bin_borrow", 32'(bus.bout), 32'd1);
        run_op(16'h00FF, 16'h000F, 1'b0, 1);
        check("diff_00F0", 32'(bus.diff), 32'h00F0);

        // Abort an operation between E2 and E3.
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_diff", 32'(bus.diff), 32'd0);
        check("abort_bout", 32'(bus.bout), 32'd0);
        check("abort_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        run_op(16'h0010, 16'h0001, 1'b0, 0);
        check("after_abort", 32'(bus.diff), 32'h000F);

        for (int i = 0; i < 1000; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 0);
        end
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
